mem_access_ctrl: RTL and testbench
==================================

# mem_access_ctrl

Multi-cycle load/store sequencer for the MEM stage of the MIPS core. Accepts one decoded memory operation from the core via a valid/ready handshake, drives the word-aligned request to data memory with byte strobes, waits for read data, and returns the lane-merged, sign/zero-extended result. It handles LB/LH/LW/LBU/LHU/LWL/LWR and SB/SH/SW/SWL/SWR with a response watchdog.

## Interface
- TIMEOUT, 255: maximum cycles spent waiting in REQ or RESP before aborting; 0 disables the watchdog.
- clk  in  1  clock; all state on posedge.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  core operation valid.
- req_ready  out  1  high only in IDLE.
- req_op  in  4  opcode[3:0]: 0 LB, 1 LH, 2 LWL, 3 LW, 4 LBU, 5 LHU, 6 LWR, 8 SB, 9 SH, 10 SWL, 11 SW, 14 SWR; others invalid.
- req_addr  in  32  effective address; ea = req_addr[1:0].
- req_rt  in  32  rt value: store data, or merge source for LWL/LWR.
- mem_valid  out  1  memory request valid.
- mem_ready  in  1  memory accepts request.
- mem_addr  out  32  {addr[31:2],2'b00}.
- mem_wen  out  1  1 = store.
- mem_wdata  out  32  lane-positioned store data.
- mem_wstrb  out  4  byte enables (0 for loads).
- mem_rdata  in  32  read data.
- mem_rvalid  in  1  read data valid.
- mem_rready  out  1  high only in RESP.
- done  out  1  one-cycle completion pulse.
- result  out  32  load result; 0 for stores/errors.
- rf_wen  out  1  with done: load completed without error.
- err  out  1  with done: invalid op, misalignment, or timeout.

## Operation
- States IDLE, REQ, RESP, DONE. Reset: state IDLE; req_ready=1; all other outputs 0; watchdog 0.
- IDLE: on req_valid, latch op/addr/rt. Invalid op or misalignment -> DONE with err. Otherwise -> REQ.
- REQ: mem_valid=1; mem_addr/wen/wdata/wstrb constant. On mem_ready: store -> DONE; load -> RESP.
- RESP: mem_rready=1; on mem_rvalid, capture merged result -> DONE.
- DONE: done=1 for one cycle, result/rf_wen/err valid -> IDLE.
- Watchdog: clears on entering REQ and RESP, increments each waiting cycle; reaching TIMEOUT -> DONE with err=1, rf_wen=0. A late mem_rvalid in IDLE is ignored.
- Loads (m = mem_rdata, little-endian): LB/LBU byte ea, sign/zero-extended; LH/LHU half ea[1]; LW m. LWL ea0 {m[7:0],rt[23:0]}, ea1 {m[15:0],rt[15:0]}, ea2 {m[23:0],rt[7:0]}, ea3 m. LWR ea0 m, ea1 {rt[31:24],m[31:8]}, ea2 {rt[31:16],m[31:16]}, ea3 {rt[31:8],m[31:24]}.
- Stores: SB strb 1<<ea, data rt[7:0]<<8*ea; SH strb 0011/1100 by ea[1], data rt[15:0]<<16*ea[1]; SW 1111, rt; SWL strb 0001/0011/0111/1111, data rt>>8*(3-ea); SWR strb 1111/1110/1100/1000, data rt<<8*ea. Unused lanes zero.

## Timing
- Handshake in cycle 0 (IDLE). Memory zero-wait: store done in cycle 2, load done in cycle 3 (REQ 1, RESP 2, DONE 3). Each memory wait cycle adds one.
- Early error: done in cycle 1; no memory traffic.
- req_valid during REQ/RESP/DONE is not accepted (req_ready=0); back-to-back accept possible the cycle after done.
- mem_ready and mem_rvalid in the same cycle while in REQ: only mem_ready is honoured; rdata is accepted in RESP.
- rst in any state: next cycle is IDLE with reset outputs; any outstanding transaction is dropped.

## Configuration
- MEM_ALIGN_CHECK_EN defined: LH/LHU/SH with addr[0]=1 and LW/SW with addr[1:0]!=0 go to DONE with err=1, no memory access.
- Undefined: no misalignment check; access issued with the lane rules above (LH/SH use ea[1], LW/SW ignore ea). Invalid-op and timeout errors apply in both cases.

## Test plan
- LB at 0x1003, memory word 0x80FF_0011 -> mem_addr 0x1000, wstrb 0, done in cycle 3, result 0xFFFF_FF80, rf_wen=1.
- SWL at 0x2001, rt 0xAABB_CCDD -> wstrb 0011, wdata 0x0000_AABB, done in cycle 2, rf_wen=0.
- LWR at 0x3002, rt 0x1122_3344, memory 0xDEAD_BEEF -> result 0x1122_DEAD.
- mem_ready held low 3 cycles for SH at 0x4002 -> mem_valid/addr/wstrb 1100 stable throughout; done in cycle 5.
- TIMEOUT=4, load with mem_rvalid never asserted -> done with err=1, rf_wen=0, result 0; a later mem_rvalid is ignored.
- LW at 0x5001 with MEM_ALIGN_CHECK_EN -> no mem_valid, done in cycle 1, err=1; op 7 -> err=1 with or without the macro.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store sequencer: one op via valid/ready, word-aligned memory request, lane-merged result.
// Optional MEM_ALIGN_CHECK_EN rejects misaligned LH/LHU/SH/LW/SW with err; TIMEOUT=0 disables the watchdog.
module mem_access_ctrl #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [3:0]  req_op_i,
  input  logic [31:0] req_addr_i,
  input  logic [31:0] req_rt_i,
  output logic        mem_valid_o,
  input  logic        mem_ready_i,
  output logic [31:0] mem_addr_o,
  output logic        mem_wen_o,
  output logic [31:0] mem_wdata_o,
  output logic [3:0]  mem_wstrb_o,
  input  logic [31:0] mem_rdata_i,
  input  logic        mem_rvalid_i,
  output logic        mem_rready_o,
  output logic        done_o,
  output logic [31:0] result_o,
  output logic        rf_wen_o,
  output logic        err_o
);

  localparam int unsigned WDW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [WDW-1:0] WD_LAST = (TIMEOUT == 0) ? '0 : WDW'(TIMEOUT - 1);

  localparam logic [3:0] OP_LB  = 4'd0;
  localparam logic [3:0] OP_LH  = 4'd1;
  localparam logic [3:0] OP_LWL = 4'd2;
  localparam logic [3:0] OP_LW  = 4'd3;
  localparam logic [3:0] OP_LBU = 4'd4;
  localparam logic [3:0] OP_LHU = 4'd5;
  localparam logic [3:0] OP_LWR = 4'd6;
  localparam logic [3:0] OP_SB  = 4'd8;
  localparam logic [3:0] OP_SH  = 4'd9;
  localparam logic [3:0] OP_SWL = 4'd10;
  localparam logic [3:0] OP_SW  = 4'd11;
  localparam logic [3:0] OP_SWR = 4'd14;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_e;

  state_e          state_q, state_d;
  logic [3:0]      op_q, op_d;
  logic [31:0]     addr_q, addr_d;
  logic [31:0]     rt_q, rt_d;
  logic [31:0]     result_q, result_d;
  logic            err_q, err_d;
  logic [WDW-1:0]  wd_q, wd_d;

  logic [1:0]      ea_q;
  logic [1:0]      inv_ea;
  logic [3:0]      st_strb;
  logic [31:0]     st_data;
  logic [31:0]     ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;
  logic            in_req;
  logic            in_done;
  logic            wd_expired;

  function automatic logic op_valid(input logic [3:0] op);
    case (op)
      OP_LB, OP_LH, OP_LWL, OP_LW, OP_LBU, OP_LHU, OP_LWR,
      OP_SB, OP_SH, OP_SWL, OP_SW, OP_SWR: return 1'b1;
      default:                             return 1'b0;
    endcase
  endfunction

  function automatic logic op_misaligned(input logic [3:0] op, input logic [1:0] ea);
    logic bad;
    bad = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if ((op == OP_LH || op == OP_LHU || op == OP_SH) && ea[0]) bad = 1'b1;
    if ((op == OP_LW || op == OP_SW) && (ea != 2'b00))         bad = 1'b1;
`else
    bad = (op == 4'hF) && (ea == 2'b11) && 1'b0;
`endif
    return bad;
  endfunction

  assign ea_q   = addr_q[1:0];
  assign inv_ea = 2'd3 - ea_q;

  always_comb begin
    st_strb = 4'b0000;
    st_data = '0;
    case (op_q)
      OP_SB: begin
        st_strb = 4'b0001 << ea_q;
        st_data = {24'b0, rt_q[7:0]} << {ea_q, 3'b000};
      end
      OP_SH: begin
        st_strb = ea_q[1] ? 4'b1100 : 4'b0011;
        st_data = ea_q[1] ? {rt_q[15:0], 16'b0} : {16'b0, rt_q[15:0]};
      end
      OP_SW: begin
        st_strb = 4'b1111;
        st_data = rt_q;
      end
      OP_SWL: begin
        st_strb = 4'b1111 >> inv_ea;
        st_data = rt_q >> {inv_ea, 3'b000};
      end
      OP_SWR: begin
        st_strb = 4'b1111 << ea_q;
        st_data = rt_q << {ea_q, 3'b000};
      end
      default: ;
    endcase
  end

  // Lane merge for the word currently presented on mem_rdata_i.
  always_comb begin
    ld_byte = mem_rdata_i[{ea_q, 3'b000} +: 8];
    ld_half = ea_q[1] ? mem_rdata_i[31:16] : mem_rdata_i[15:0];
    ld_data = '0;
    case (op_q)
      OP_LB:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      OP_LBU: ld_data = {24'b0, ld_byte};
      OP_LH:  ld_data = {{16{ld_half[15]}}, ld_half};
      OP_LHU: ld_data = {16'b0, ld_half};
      OP_LW:  ld_data = mem_rdata_i;
      OP_LWL: begin
        case (ea_q)
          2'd0:    ld_data = {mem_rdata_i[7:0],  rt_q[23:0]};
          2'd1:    ld_data = {mem_rdata_i[15:0], rt_q[15:0]};
          2'd2:    ld_data = {mem_rdata_i[23:0], rt_q[7:0]};
          default: ld_data = mem_rdata_i;
        endcase
      end
      OP_LWR: begin
        case (ea_q)
          2'd0:    ld_data = mem_rdata_i;
          2'd1:    ld_data = {rt_q[31:24], mem_rdata_i[31:8]};
          2'd2:    ld_data = {rt_q[31:16], mem_rdata_i[31:16]};
          default: ld_data = {rt_q[31:8],  mem_rdata_i[31:24]};
        endcase
      end
      default: ;
    endcase
  end

  assign wd_expired = (TIMEOUT != 0) && (wd_q == WD_LAST);

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    addr_d   = addr_q;
    rt_d     = rt_q;
    result_d = result_q;
    err_d    = err_q;
    wd_d     = wd_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          op_d     = req_op_i;
          addr_d   = req_addr_i;
          rt_d     = req_rt_i;
          result_d = '0;
          wd_d     = '0;
          if (!op_valid(req_op_i) || op_misaligned(req_op_i, req_addr_i[1:0])) begin
            err_d   = 1'b1;
            state_d = S_DONE;
          end else begin
            err_d   = 1'b0;
            state_d = S_REQ;
          end
        end
      end
      S_REQ: begin
        if (mem_ready_i) begin
          wd_d    = '0;
          state_d = op_q[3] ? S_DONE : S_RESP;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        if (mem_rvalid_i) begin
          result_d = ld_data;
          state_d  = S_DONE;
        end else if (wd_expired) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else if (TIMEOUT != 0) begin
          wd_d = wd_q + 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= S_IDLE;
      op_q     <= '0;
      addr_q   <= '0;
      rt_q     <= '0;
      result_q <= '0;
      err_q    <= 1'b0;
      wd_q     <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      addr_q   <= addr_d;
      rt_q     <= rt_d;
      result_q <= result_d;
      err_q    <= err_d;
      wd_q     <= wd_d;
    end
  end

  assign in_req  = (state_q == S_REQ);
  assign in_done = (state_q == S_DONE);

  assign req_ready_o  = (state_q == S_IDLE);
  assign mem_valid_o  = in_req;
  assign mem_addr_o   = in_req ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wen_o    = in_req & op_q[3];
  assign mem_wdata_o  = in_req ? st_data : '0;
  assign mem_wstrb_o  = in_req ? st_strb : 4'b0000;
  assign mem_rready_o = (state_q == S_RESP);
  assign done_o       = in_done;
  assign result_o     = (in_done && !err_q) ? result_q : '0;
  assign err_o        = in_done & err_q;
  assign rf_wen_o     = in_done & ~err_q & ~op_q[3];

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized and directed checks of mem_access_ctrl against a byte-lane reference model.
module tb_mem_access_ctrl;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_op = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_rt = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic [31:0] mem_addr;
  logic        mem_wen;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata = '0;
  logic        mem_rvalid = 1'b0;
  logic        mem_rready;
  logic        done;
  logic [31:0] result;
  logic        rf_wen;
  logic        err;

  int vectors = 0;
  int miscompares = 0;

  mem_access_ctrl #(.TIMEOUT(TO)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready),
    .req_op_i(req_op), .req_addr_i(req_addr), .req_rt_i(req_rt),
    .mem_valid_o(mem_valid), .mem_ready_i(mem_ready), .mem_addr_o(mem_addr),
    .mem_wen_o(mem_wen), .mem_wdata_o(mem_wdata), .mem_wstrb_o(mem_wstrb),
    .mem_rdata_i(mem_rdata), .mem_rvalid_i(mem_rvalid), .mem_rready_o(mem_rready),
    .done_o(done), .result_o(result), .rf_wen_o(rf_wen), .err_o(err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] byte_of(input logic [31:0] w, input int i);
    return w[8*i +: 8];
  endfunction

  function automatic bit is_valid(input logic [3:0] op);
    return op inside {4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14};
  endfunction

  function automatic bit misal(input logic [3:0] op, input int e);
    bit m;
    m = 1'b0;
`ifdef MEM_ALIGN_CHECK_EN
    if (op inside {4'd1, 4'd5, 4'd9} && (e % 2 == 1)) m = 1'b1;
    if (op inside {4'd3, 4'd11} && e != 0)            m = 1'b1;
`else
    if (op == 4'd15 && e > 3) m = 1'b1;
`endif
    return m;
  endfunction

  // Load result built byte by byte from the architectural rules.
  function automatic logic [31:0] model_load(input logic [3:0] op, input int e,
                                             input logic [31:0] rt, input logic [31:0] m);
    logic [31:0] r;
    logic [7:0]  b;
    logic [15:0] h;
    r = '0;
    b = byte_of(m, e);
    h = {byte_of(m, 2*(e/2) + 1), byte_of(m, 2*(e/2))};
    case (op)
      4'd0: r = 32'($signed(b));
      4'd4: r = 32'(b);
      4'd1: r = 32'($signed(h));
      4'd5: r = 32'(h);
      4'd3: r = m;
      4'd2: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i >= 3 - e) ? byte_of(m, i - (3 - e)) : byte_of(rt, i);
      4'd6: for (int i = 0; i < 4; i++) r[8*i +: 8] = (i <= 3 - e) ? byte_of(m, i + e) : byte_of(rt, i);
      default: r = '0;
    endcase
    return r;
  endfunction

  // Returns {strobe, data} for a store.
  function automatic logic [35:0] model_store(input logic [3:0] op, input int e, input logic [31:0] rt);
    logic [3:0]  s;
    logic [31:0] d;
    s = '0;
    d = '0;
    for (int i = 0; i < 4; i++) begin
      case (op)
        4'd8:  if (i == e)           begin s[i] = 1'b1; d[8*i +: 8] = byte_of(rt, 0); end
        4'd9:  if (i / 2 == e / 2)   begin s[i] = 1'b1; d[8*i +: 8] = byte_of(rt, i % 2); end
        4'd11: begin s[i] = 1'b1; d[8*i +: 8] = byte_of(rt, i); end
        4'd10: if (i <= e)           begin s[i] = 1'b1; d[8*i +: 8] = byte_of(rt, i + 3 - e); end
        4'd14: if (i >= e)           begin s[i] = 1'b1; d[8*i +: 8] = byte_of(rt, i - e); end
        default: ;
      endcase
    end
    return {s, d};
  endfunction

  // Issue one op at cycle 0 and play the memory side; returns one cycle after done.
  task automatic run_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] rt,
                        input logic [31:0] mdata, input int rdy_dly, input int rv_dly, input bit rv_never);
    int          e;
    bit          early, store, seen, saw_mem;
    int          cyc, wreq, wresp;
    logic [35:0] sw;
    e       = int'(addr[1:0]);
    early   = !is_valid(op) || misal(op, e);
    store   = op[3];
    sw      = model_store(op, e, rt);
    cyc     = 0;
    wreq    = 0;
    wresp   = 0;
    seen    = 1'b0;
    saw_mem = 1'b0;
    chk("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1;
    req_op    = op;
    req_addr  = addr;
    req_rt    = rt;
    while (!seen && cyc < 20) begin
      tick();
      cyc++;
      req_op     = 4'($urandom);
      req_addr   = $urandom;
      req_rt     = $urandom;
      mem_ready  = 1'b0;
      mem_rvalid = 1'b0;
      mem_rdata  = $urandom;
      chk("req_ready_busy", 32'(req_ready), 32'd0);
      if (mem_valid) begin
        saw_mem = 1'b1;
        chk("mem_addr",  mem_addr, {addr[31:2], 2'b00});
        chk("mem_wen",   32'(mem_wen), 32'(store));
        chk("mem_wstrb", 32'(mem_wstrb), 32'(sw[35:32]));
        chk("mem_wdata", mem_wdata, store ? sw[31:0] : 32'd0);
        if (wreq == rdy_dly) mem_ready = 1'b1;
        mem_rvalid = 1'($urandom);
        wreq++;
      end
      if (mem_rready) begin
        if (!rv_never && wresp == rv_dly) begin
          mem_rvalid = 1'b1;
          mem_rdata  = mdata;
        end
        wresp++;
      end
      if (done) begin
        seen = 1'b1;
        if (early) begin
          chk("err_early", 32'(err), 32'd1);
          chk("rf_wen_early", 32'(rf_wen), 32'd0);
          chk("result_early", result, 32'd0);
          chk("cycle_early", 32'(cyc), 32'd1);
        end else if (store) begin
          chk("err_store", 32'(err), 32'd0);
          chk("rf_wen_store", 32'(rf_wen), 32'd0);
          chk("result_store", result, 32'd0);
          chk("cycle_store", 32'(cyc), 32'(2 + rdy_dly));
        end else if (rv_never) begin
          chk("err_timeout", 32'(err), 32'd1);
          chk("rf_wen_timeout", 32'(rf_wen), 32'd0);
          chk("result_timeout", result, 32'd0);
          chk("cycle_timeout", 32'(cyc >= int'(2 + TO) && cyc <= int'(3 + TO)), 32'd1);
        end else begin
          chk("err_load", 32'(err), 32'd0);
          chk("rf_wen_load", 32'(rf_wen), 32'd1);
          chk("result_load", result, model_load(op, e, rt, mdata));
          chk("cycle_load", 32'(cyc), 32'(3 + rdy_dly + rv_dly));
        end
      end
    end
    chk("done_seen", 32'(seen), 32'd1);
    chk("mem_traffic", 32'(saw_mem), 32'(!early));
    req_valid  = 1'b0;
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
    tick();
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_mem_valid"}, 32'(mem_valid), 32'd0);
    chk({tag, "_mem_rready"}, 32'(mem_rready), 32'd0);
    chk({tag, "_done"}, 32'(done), 32'd0);
    chk({tag, "_result"}, result, 32'd0);
    chk({tag, "_err_rfwen"}, {30'd0, err, rf_wen}, 32'd0);
    chk({tag, "_mem_outs"}, mem_addr | mem_wdata | 32'(mem_wstrb) | 32'(mem_wen), 32'd0);
  endtask

  initial begin
    logic [3:0] ops [13];
    ops = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9, 4'd10, 4'd11, 4'd14, 4'd7};

    tick();
    tick();
    chk_idle("reset");
    rst = 1'b0;
    tick();

    run_op(4'd0,  32'h0000_1003, $urandom,      32'h80FF_0011, 0, 0, 1'b0);
    run_op(4'd10, 32'h0000_2001, 32'hAABB_CCDD, $urandom,      0, 0, 1'b0);
    run_op(4'd6,  32'h0000_3002, 32'h1122_3344, 32'hDEAD_BEEF, 0, 0, 1'b0);
    run_op(4'd9,  32'h0000_4002, $urandom,      $urandom,      3, 0, 1'b0);
    run_op(4'd3,  32'h0000_5000, $urandom,      $urandom,      0, 0, 1'b1);

    mem_rvalid = 1'b1;
    mem_rdata  = 32'hCAFE_F00D;
    tick();
    chk_idle("late_rvalid");
    tick();
    chk("late_rvalid_done", 32'(done), 32'd0);
    mem_rvalid = 1'b0;

    run_op(4'd3,  32'h0000_5001, $urandom, 32'h1234_5678, 0, 0, 1'b0);
    run_op(4'd11, 32'h0000_5002, $urandom, $urandom,      1, 0, 1'b0);
    run_op(4'd1,  32'h0000_5003, $urandom, 32'h8765_4321, 0, 1, 1'b0);
    run_op(4'd7,  32'h0000_6000, $urandom, $urandom,      0, 0, 1'b0);
    run_op(4'd15, 32'h0000_6004, $urandom, $urandom,      0, 0, 1'b0);

    req_valid = 1'b1;
    req_op    = 4'd3;
    req_addr  = 32'h0000_7000;
    tick();
    req_valid = 1'b0;
    chk("rst_mid_in_req", 32'(mem_valid), 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk_idle("rst_mid");

    for (int n = 0; n < 250; n++) begin
      run_op(ops[$urandom_range(0, 12)], $urandom, $urandom, $urandom,
             int'($urandom_range(0, 2)), int'($urandom_range(0, 2)), 1'b0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
